reservation_station: RTL and testbench

//  Holds ALU-class ops (RC/RI/BR/JAL/JALR/LUI/AUIPC) issued by the decoder on rs_enable until both

---
 rtl/reservation_station_if.sv | 53 +++++
 rtl/reservation_station.sv | 146 ++++++++++++++
 tb/tb_reservation_station.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reservation_station_if.sv
// Decoder/ALU-side bus of the reservation station: issue port, two result
// snoop buses and the dispatch port toward the ALU.
interface reservation_station_if #(
    parameter int ROB_POS_W = 5,
    parameter int DATA_W    = 32,
    parameter int OPENUM_W  = 6
);
    logic                 rs_enable;
    logic [OPENUM_W-1:0]  issue_openum;
    logic [DATA_W-1:0]    issue_rs1_val;
    logic [ROB_POS_W-1:0] issue_rs1_rob_pos;
    logic [DATA_W-1:0]    issue_rs2_val;
    logic [ROB_POS_W-1:0] issue_rs2_rob_pos;
    logic [DATA_W-1:0]    issue_imm;
    logic [DATA_W-1:0]    issue_pc;
    logic                 issue_pred_jump;
    logic [ROB_POS_W-1:0] issue_rob_pos;

    logic                 alu_result_ready;
    logic [ROB_POS_W-1:0] alu_result_rob_pos;
    logic [DATA_W-1:0]    alu_result_val;
    logic                 lsb_result_ready;
    logic [ROB_POS_W-1:0] lsb_result_rob_pos;
    logic [DATA_W-1:0]    lsb_result_val;

    logic                 rs_full;
    logic                 alu_enable;
    logic [OPENUM_W-1:0]  alu_openum;
    logic [DATA_W-1:0]    alu_rs1_val;
    logic [DATA_W-1:0]    alu_rs2_val;
    logic [DATA_W-1:0]    alu_imm;
    logic [DATA_W-1:0]    alu_pc;
    logic                 alu_pred_jump;
    logic [ROB_POS_W-1:0] alu_rob_pos;

    modport master (
        output rs_enable, issue_openum, issue_rs1_val, issue_rs1_rob_pos, issue_rs2_val,
               issue_rs2_rob_pos, issue_imm, issue_pc, issue_pred_jump, issue_rob_pos,
               alu_result_ready, alu_result_rob_pos, alu_result_val,
               lsb_result_ready, lsb_result_rob_pos, lsb_result_val,
        input  rs_full, alu_enable, alu_openum, alu_rs1_val, alu_rs2_val, alu_imm,
               alu_pc, alu_pred_jump, alu_rob_pos
    );

    modport slave (
        input  rs_enable, issue_openum, issue_rs1_val, issue_rs1_rob_pos, issue_rs2_val,
               issue_rs2_rob_pos, issue_imm, issue_pc, issue_pred_jump, issue_rob_pos,
               alu_result_ready, alu_result_rob_pos, alu_result_val,
               lsb_result_ready, lsb_result_rob_pos, lsb_result_val,
        output rs_full, alu_enable, alu_openum, alu_rs1_val, alu_rs2_val, alu_imm,
               alu_pc, alu_pred_jump, alu_rob_pos
    );
endinterface

// File: rtl/reservation_station.sv
// ALU reservation station: holds issued ops until both operands resolve via the
// ALU/LSB result buses, then dispatches the lowest-index ready entry each cycle.
module reservation_station #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_POS_W = 5,
    parameter int DATA_W    = 32,
    parameter int OPENUM_W  = 6
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  rdy,
    input logic                  rollback,
    reservation_station_if.slave io
);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [ROB_POS_W-1:0] q;
        logic [DATA_W-1:0]    v;
    } opnd_t;

    typedef struct packed {
        logic                 ready;
        logic [ROB_POS_W-1:0] tag;
        logic [DATA_W-1:0]    val;
    } bcast_t;

    typedef struct packed {
        logic                 valid;
        logic [OPENUM_W-1:0]  openum;
        opnd_t                s1;
        opnd_t                s2;
        logic [DATA_W-1:0]    imm;
        logic [DATA_W-1:0]    pc;
        logic                 pred_jump;
        logic [ROB_POS_W-1:0] rob_pos;
    } entry_t;

    // Tag 0 means "already valid" and must never be captured; ALU bus wins a tie.
    function automatic opnd_t snoop(opnd_t o, bcast_t a, bcast_t l);
        opnd_t r;
        r = o;
        if (o.q != '0) begin
            if (a.ready && a.tag == o.q) begin
                r.q = '0;
                r.v = a.val;
            end else if (l.ready && l.tag == o.q) begin
                r.q = '0;
                r.v = l.val;
            end
        end
        return r;
    endfunction

    entry_t             ent   [RS_SIZE];
    entry_t             ent_w [RS_SIZE];
    entry_t             inc;
    bcast_t             alu_b, lsb_b;
    logic [RS_SIZE-1:0] ready;
    logic               disp_any, free_any, issue_ok;
    logic [IDX_W-1:0]   disp_idx, free_idx;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    assign alu_b = '{ready: io.alu_result_ready, tag: io.alu_result_rob_pos, val: io.alu_result_val};
    assign lsb_b = '{ready: io.lsb_result_ready, tag: io.lsb_result_rob_pos, val: io.lsb_result_val};

    always_comb begin
        disp_any = 1'b0;
        disp_idx = '0;
        free_any = 1'b0;
        free_idx = '0;
        cnt      = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i]    = ent[i].valid && ent[i].s1.q == '0 && ent[i].s2.q == '0;
            ent_w[i]    = ent[i];
            ent_w[i].s1 = snoop(ent[i].s1, alu_b, lsb_b);
            ent_w[i].s2 = snoop(ent[i].s2, alu_b, lsb_b);
            cnt         = cnt + CNT_W'(ent[i].valid);
        end
        // Descending scan so the lowest index is the one left standing.
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                disp_any = 1'b1;
                disp_idx = IDX_W'(i);
            end
            if (!ent[i].valid) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        issue_ok = io.rs_enable && free_any;
        cnt_nxt  = cnt + CNT_W'(issue_ok) - CNT_W'(disp_any);

        inc.valid     = 1'b1;
        inc.openum    = io.issue_openum;
        inc.s1        = snoop('{q: io.issue_rs1_rob_pos, v: io.issue_rs1_val}, alu_b, lsb_b);
        inc.s2        = snoop('{q: io.issue_rs2_rob_pos, v: io.issue_rs2_val}, alu_b, lsb_b);
        inc.imm       = io.issue_imm;
        inc.pc        = io.issue_pc;
        inc.pred_jump = io.issue_pred_jump;
        inc.rob_pos   = io.issue_rob_pos;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
            io.rs_full       <= 1'b0;
            io.alu_enable    <= 1'b0;
            io.alu_openum    <= '0;
            io.alu_rs1_val   <= '0;
            io.alu_rs2_val   <= '0;
            io.alu_imm       <= '0;
            io.alu_pc        <= '0;
            io.alu_pred_jump <= 1'b0;
            io.alu_rob_pos   <= '0;
        end else if (!rdy) begin
            io.alu_enable <= 1'b0;
        end else if (rollback) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i].valid <= 1'b0;
            io.alu_enable <= 1'b0;
            io.rs_full    <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) ent[i] <= ent_w[i];
            // Free slot was chosen before dispatch, so a slot freed now is not refilled this edge.
            if (disp_any) ent[disp_idx].valid <= 1'b0;
            if (issue_ok) ent[free_idx] <= inc;
            io.alu_enable <= disp_any;
            if (disp_any) begin
                io.alu_openum    <= ent[disp_idx].openum;
                io.alu_rs1_val   <= ent[disp_idx].s1.v;
                io.alu_rs2_val   <= ent[disp_idx].s2.v;
                io.alu_imm       <= ent[disp_idx].imm;
                io.alu_pc        <= ent[disp_idx].pc;
                io.alu_pred_jump <= ent[disp_idx].pred_jump;
                io.alu_rob_pos   <= ent[disp_idx].rob_pos;
            end
            io.rs_full <= cnt_nxt >= CNT_W'(RS_SIZE - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && rdy && !rollback && io.rs_enable && !free_any)
            $error("reservation_station: issue dropped, no free entry");
    end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: a slot-array model tracks expected
// dispatch/full every cycle, plus literal spot checks per scenario.
module tb_reservation_station;
    localparam int RS_SIZE = 16;
    localparam int RW = 5;
    localparam int DW = 32;
    localparam int OW = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic rollback = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    reservation_station_if #(.ROB_POS_W(RW), .DATA_W(DW), .OPENUM_W(OW)) io ();

    reservation_station #(.RS_SIZE(RS_SIZE), .ROB_POS_W(RW), .DATA_W(DW), .OPENUM_W(OW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .io(io)
    );

    typedef struct packed {
        logic [OW-1:0] op;
        logic [DW-1:0] v1;
        logic [RW-1:0] q1;
        logic [DW-1:0] v2;
        logic [RW-1:0] q2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
        logic          pj;
        logic [RW-1:0] rob;
    } op_t;

    op_t                m_slot [RS_SIZE];
    logic [RS_SIZE-1:0] m_v = '0;
    op_t                exp_o = '0;
    logic               exp_en = 1'b0;
    logic               exp_full = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A pending operand picks up a broadcast with its tag; ALU has priority.
    function automatic void snoop(inout logic [RW-1:0] q, inout logic [DW-1:0] v);
        if (q != '0) begin
            if (io.alu_result_ready && io.alu_result_rob_pos == q) begin
                v = io.alu_result_val;
                q = '0;
            end else if (io.lsb_result_ready && io.lsb_result_rob_pos == q) begin
                v = io.lsb_result_val;
                q = '0;
            end
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        int d, f;
        if (!rst) begin
            m_v = '0; exp_en = 1'b0; exp_full = 1'b0; exp_o = '0;
        end else if (!rdy) begin
            exp_en = 1'b0;
        end else if (rollback) begin
            m_v = '0; exp_en = 1'b0; exp_full = 1'b0;
        end else begin
            d = -1; f = -1;
            for (int i = 0; i < RS_SIZE; i++) begin
                if (d < 0 && m_v[i] && m_slot[i].q1 == '0 && m_slot[i].q2 == '0) d = i;
                if (f < 0 && !m_v[i]) f = i;
            end
            exp_en = (d >= 0);
            if (d >= 0) begin
                exp_o = m_slot[d];
                m_v[d] = 1'b0;
            end
            for (int i = 0; i < RS_SIZE; i++)
                if (m_v[i]) begin
                    snoop(m_slot[i].q1, m_slot[i].v1);
                    snoop(m_slot[i].q2, m_slot[i].v2);
                end
            if (io.rs_enable && f >= 0) begin
                op_t o;
                o.op = io.issue_openum; o.imm = io.issue_imm; o.pc = io.issue_pc;
                o.pj = io.issue_pred_jump; o.rob = io.issue_rob_pos;
                o.q1 = io.issue_rs1_rob_pos; o.v1 = io.issue_rs1_val;
                o.q2 = io.issue_rs2_rob_pos; o.v2 = io.issue_rs2_val;
                snoop(o.q1, o.v1);
                snoop(o.q2, o.v2);
                m_slot[f] = o;
                m_v[f] = 1'b1;
            end
            exp_full = ($countones(m_v) >= RS_SIZE - 1);
        end
    end

    always @(negedge clk) begin
        chk("cmp_en",   DW'(io.alu_enable),    DW'(exp_en));
        chk("cmp_full", DW'(io.rs_full),       DW'(exp_full));
        chk("cmp_op",   DW'(io.alu_openum),    DW'(exp_o.op));
        chk("cmp_rs1",  io.alu_rs1_val,        exp_o.v1);
        chk("cmp_rs2",  io.alu_rs2_val,        exp_o.v2);
        chk("cmp_imm",  io.alu_imm,            exp_o.imm);
        chk("cmp_pc",   io.alu_pc,             exp_o.pc);
        chk("cmp_pj",   DW'(io.alu_pred_jump), DW'(exp_o.pj));
        chk("cmp_rob",  DW'(io.alu_rob_pos),   DW'(exp_o.rob));
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        io.rs_enable = 1'b0;
        io.alu_result_ready = 1'b0;
        io.lsb_result_ready = 1'b0;
        rollback = 1'b0;
    endtask

    task automatic iss(input logic [OW-1:0] op, input logic [RW-1:0] q1, input logic [DW-1:0] v1,
                       input logic [RW-1:0] q2, input logic [DW-1:0] v2, input logic [DW-1:0] imm,
                       input logic [RW-1:0] rob);
        io.rs_enable = 1'b1;
        io.issue_openum = op;
        io.issue_rs1_rob_pos = q1; io.issue_rs1_val = v1;
        io.issue_rs2_rob_pos = q2; io.issue_rs2_val = v2;
        io.issue_imm = imm;
        io.issue_pc = 32'h1000 + (DW'(rob) << 2);
        io.issue_pred_jump = rob[0];
        io.issue_rob_pos = rob;
    endtask

    task automatic bc(input logic av, input logic [RW-1:0] aq, input logic [DW-1:0] ad,
                      input logic lv, input logic [RW-1:0] lq, input logic [DW-1:0] ld);
        io.alu_result_ready = av; io.alu_result_rob_pos = aq; io.alu_result_val = ad;
        io.lsb_result_ready = lv; io.lsb_result_rob_pos = lq; io.lsb_result_val = ld;
    endtask

    initial begin
        idle();
        iss('0, '0, '0, '0, '0, '0, '0);
        io.rs_enable = 1'b0;
        bc(1'b0, '0, '0, 1'b0, '0, '0);
        step();
        chk("rst_en",   DW'(io.alu_enable), 32'd0);
        chk("rst_full", DW'(io.rs_full), 32'd0);
        chk("rst_rob",  DW'(io.alu_rob_pos), 32'd0);
        rst = 1'b1;

        // 1: ADDI ready at issue
        iss(6'd1, 5'd0, 32'd5, 5'd0, 32'd0, 32'd3, 5'd2); step(); idle();
        chk("t1_early", DW'(io.alu_enable), 32'd0);
        step();
        chk("t1_en", DW'(io.alu_enable), 32'd1);
        chk("t1_rs1", io.alu_rs1_val, 32'd5);
        chk("t1_imm", io.alu_imm, 32'd3);
        chk("t1_rob", DW'(io.alu_rob_pos), 32'd2);
        step();
        chk("t1_off", DW'(io.alu_enable), 32'd0);

        // 2: wakeup from ALU two cycles later
        iss(6'd2, 5'd4, 32'd0, 5'd0, 32'd7, 32'd0, 5'd3); step(); idle();
        step();
        bc(1'b1, 5'd4, 32'h10, 1'b0, 5'd0, 32'd0); step(); idle();
        chk("t2_wait", DW'(io.alu_enable), 32'd0);
        step();
        chk("t2_en", DW'(io.alu_enable), 32'd1);
        chk("t2_rs1", io.alu_rs1_val, 32'h10);
        chk("t2_rs2", io.alu_rs2_val, 32'd7);

        // 3: LSB broadcast on the issue cycle
        iss(6'd3, 5'd7, 32'd0, 5'd0, 32'd0, 32'd0, 5'd5);
        bc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd9); step(); idle();
        step();
        chk("t3_en", DW'(io.alu_enable), 32'd1);
        chk("t3_rs1", io.alu_rs1_val, 32'd9);
        chk("t3_rob", DW'(io.alu_rob_pos), 32'd5);

        // 4: fill to RS_SIZE-1, then free one
        for (int k = 0; k < 15; k++) begin
            iss(6'd4, RW'(10 + k), 32'd0, 5'd0, 32'd1, DW'(k), RW'(k + 1)); step();
            if (k == 13) chk("t4_n14", DW'(io.rs_full), 32'd0);
        end
        idle();
        chk("t4_full", DW'(io.rs_full), 32'd1);
        bc(1'b1, 5'd10, 32'h100, 1'b0, 5'd0, 32'd0); step(); idle();
        chk("t4_woken", DW'(io.rs_full), 32'd1);
        step();
        chk("t4_disp", DW'(io.alu_enable), 32'd1);
        chk("t4_rob", DW'(io.alu_rob_pos), 32'd1);
        chk("t4_free", DW'(io.rs_full), 32'd0);
        for (int t = 11; t <= 23; t += 2) begin
            bc(1'b1, RW'(t), DW'(t), 1'b1, RW'(t + 1), DW'(t + 1)); step(); idle();
        end
        for (int n = 0; n < 16; n++) step();

        // 5: lowest index first; slot freed by dispatch not reused on the same edge
        for (int k = 0; k < 4; k++) begin
            iss(6'd5, RW'(20 + k), 32'd0, 5'd0, 32'd0, 32'd0, RW'(k + 1)); step();
        end
        idle();
        bc(1'b1, 5'd23, 32'h23, 1'b1, 5'd21, 32'h21); step(); idle();
        chk("t5_wait", DW'(io.alu_enable), 32'd0);
        iss(6'd6, 5'd0, 32'h99, 5'd0, 32'd0, 32'd0, 5'd9); step(); idle();
        chk("t5_first", DW'(io.alu_rob_pos), 32'd2);
        chk("t5_first_rs1", io.alu_rs1_val, 32'h21);
        step();
        chk("t5_second", DW'(io.alu_rob_pos), 32'd4);
        chk("t5_second_rs1", io.alu_rs1_val, 32'h23);
        step();
        chk("t5_reuse", DW'(io.alu_rob_pos), 32'd9);
        bc(1'b1, 5'd20, 32'h20, 1'b1, 5'd22, 32'h22); step(); idle();
        step();
        chk("t5_rob1", DW'(io.alu_rob_pos), 32'd1);
        step();
        chk("t5_rob3", DW'(io.alu_rob_pos), 32'd3);

        // both operands wake together; ALU wins a same-tag tie at issue
        iss(6'd7, 5'd25, 32'd0, 5'd26, 32'd0, 32'd0, 5'd12); step(); idle();
        bc(1'b1, 5'd25, 32'hA, 1'b1, 5'd26, 32'hB); step(); idle();
        step();
        chk("t7_rs1", io.alu_rs1_val, 32'hA);
        chk("t7_rs2", io.alu_rs2_val, 32'hB);
        iss(6'd8, 5'd27, 32'd0, 5'd0, 32'd0, 32'd0, 5'd13);
        bc(1'b1, 5'd27, 32'd1, 1'b1, 5'd27, 32'd2); step(); idle();
        step();
        chk("t8_prio", io.alu_rs1_val, 32'd1);

        // stall holds the ready op
        iss(6'd9, 5'd0, 32'h66, 5'd0, 32'd0, 32'd0, 5'd6); step(); idle();
        rdy = 1'b0;
        step();
        chk("st_en0", DW'(io.alu_enable), 32'd0);
        step();
        chk("st_en1", DW'(io.alu_enable), 32'd0);
        rdy = 1'b1;
        step();
        chk("st_go", DW'(io.alu_enable), 32'd1);
        chk("st_rob", DW'(io.alu_rob_pos), 32'd6);

        // 6: rollback with 10 pending ops
        for (int k = 0; k < 10; k++) begin
            iss(6'd10, RW'(k + 1), 32'd0, 5'd0, 32'd0, 32'd0, RW'(k + 1)); step();
        end
        idle();
        rollback = 1'b1; step(); idle();
        chk("rb_en", DW'(io.alu_enable), 32'd0);
        chk("rb_full", DW'(io.rs_full), 32'd0);
        bc(1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 32'd2); step(); idle();
        step();
        chk("rb_none", DW'(io.alu_enable), 32'd0);
        iss(6'd11, 5'd0, 32'h55, 5'd0, 32'd0, 32'd0, 5'd9); step(); idle();
        step();
        chk("rb_new", DW'(io.alu_enable), 32'd1);
        chk("rb_new_rob", DW'(io.alu_rob_pos), 32'd9);
        chk("rb_new_rs1", io.alu_rs1_val, 32'h55);

        // asynchronous reset mid-operation
        iss(6'd12, 5'd3, 32'd0, 5'd0, 32'd0, 32'd0, 5'd3); step(); idle();
        #2 rst = 1'b0;
        #1;
        chk("mr_rob", DW'(io.alu_rob_pos), 32'd0);
        chk("mr_rs1", io.alu_rs1_val, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bc(1'b1, 5'd3, 32'd3, 1'b0, 5'd0, 32'd0); step(); idle();
        step();
        chk("mr_stale", DW'(io.alu_enable), 32'd0);

        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
